// File: rtl/kalman_pkg.sv
// Shared types and constants for the Kalman filter datapath stages.
package kalman_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CKSUM = 2'd2
    } ser_state_t;

    localparam int STATE_W = 16;
    localparam int NOS     = 4;

    // Bits needed to count 0..n inclusive (covers the checksum slot).
    function automatic int idx_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int IDX_W = idx_w(NOS);

endpackage

// File: rtl/kalman_ser_buffer.sv
// Snapshot register file for the state serializer: parallel load,
// indexed read. Out-of-range indices read as zero.
module kalman_ser_buffer
    import kalman_pkg::*;
#(
    parameter int WIDTH = STATE_W,
    parameter int DEPTH = NOS,
    parameter int IW    = idx_w(NOS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din [0:DEPTH-1],
    input  logic [IW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= din[i];
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++)
            if (rd_idx == IW'(i)) rd_data = mem[i];
    end

endmodule

// File: rtl/kalman_state_serializer.sv
// Streams a snapshot of the Kalman state vector one word per handshake.
// Define STATE_SER_CHECKSUM_EN to append an XOR checksum word per frame.
module kalman_state_serializer
    import kalman_pkg::*;
#(
    parameter int WIDTH      = STATE_W,
    parameter int nos        = NOS,
    parameter int FRAME_ID_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_en,
    input  logic                       start,
    input  logic [WIDTH-1:0]           State [0:nos-1],
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [$clog2(nos+1)-1:0]   out_index,
    output logic [FRAME_ID_W-1:0]      frame_id,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);

    localparam int IW = idx_w(nos);

    ser_state_t       state_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] buf_word;
    logic             load;
    logic             xfer;
    logic             last_word;
    logic             frame_end;

    assign load      = clk_en && start && (state_q == IDLE);
    assign xfer      = clk_en && out_valid && out_ready;
    assign last_word = (idx_q == IW'(nos - 1));

    kalman_ser_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (nos),
        .IW    (IW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .din     (State),
        .rd_idx  (idx_q),
        .rd_data (buf_word)
    );

`ifdef STATE_SER_CHECKSUM_EN
    logic [WIDTH-1:0] cksum_d;
    logic [WIDTH-1:0] cksum_q;

    // Folded at snapshot time so the buffer needs only one read port.
    always_comb begin
        cksum_d = '0;
        for (int i = 0; i < nos; i++) cksum_d = cksum_d ^ State[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     cksum_q <= '0;
        else if (load) cksum_q <= cksum_d;
    end

    assign frame_end = xfer && (state_q == CKSUM);
`else
    assign frame_end = xfer && (state_q == SEND) && last_word;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            frame_id <= '0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else if (clk_en) begin
            done <= frame_end;
            if (start && state_q != IDLE) overrun <= 1'b1;
            if (frame_end) frame_id <= frame_id + FRAME_ID_W'(1);
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SEND;
                        idx_q   <= '0;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (last_word) begin
`ifdef STATE_SER_CHECKSUM_EN
                            state_q <= CKSUM;
                            idx_q   <= IW'(nos);
`else
                            state_q <= IDLE;
                            idx_q   <= '0;
`endif
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                CKSUM: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = busy;
    assign out_index = idx_q;

`ifdef STATE_SER_CHECKSUM_EN
    assign out_data = (state_q == CKSUM) ? cksum_q :
                      (state_q == SEND)  ? buf_word : '0;
    assign out_last = (state_q == CKSUM);
`else
    assign out_data = (state_q == SEND) ? buf_word : '0;
    assign out_last = (state_q == SEND) && last_word;
`endif

endmodule

// File: tb/tb_kalman_state_serializer.sv
// Scoreboard bench for kalman_state_serializer (default nos=4, WIDTH=16).
module tb_kalman_state_serializer;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int FW = 8;
`ifdef STATE_SER_CHECKSUM_EN
    localparam int NW = N + 1;
`else
    localparam int NW = N;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  i;
        logic        l;
        logic [7:0]  f;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_en;
    logic          start;
    logic [W-1:0]  state_vec [0:N-1];
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [2:0]    out_index;
    logic [FW-1:0] frame_id;
    logic          busy;
    logic          done;
    logic          overrun;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_cnt = 0;
    logic [7:0]  exp_fid = 8'd0;

    kalman_state_serializer #(
        .WIDTH      (W),
        .nos        (N),
        .FRAME_ID_W (FW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .start     (start),
        .State     (state_vec),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_index (out_index),
        .frame_id  (frame_id),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm,
                                  input logic [31:0] act,
                                  input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endfunction

    // Monitor: a word whose handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (!reset && clk_en && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h, required none",
                         out_data);
            end else begin
                mon_e = sb.pop_front();
                check("word_data",  32'(out_data),  32'(mon_e.d));
                check("word_index", 32'(out_index), 32'(mon_e.i));
                check("word_last",  32'(out_last),  32'(mon_e.l));
                check("word_fid",   32'(frame_id),  32'(mon_e.f));
            end
        end
    end

    always @(negedge clk) if (clk_en && done) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d);
        logic [15:0] w [0:3];
        logic [15:0] x;
        exp_t e;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        x = a ^ b ^ c ^ d;
        for (int i = 0; i < N; i++) begin
            e.d = w[i];
            e.i = 3'(i);
`ifdef STATE_SER_CHECKSUM_EN
            e.l = 1'b0;
`else
            e.l = (i == N - 1);
`endif
            e.f = exp_fid;
            sb.push_back(e);
        end
`ifdef STATE_SER_CHECKSUM_EN
        e.d = x; e.i = 3'(N); e.l = 1'b1; e.f = exp_fid;
        sb.push_back(e);
`endif
    endtask

    task automatic do_start(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d,
                            input bit push);
        state_vec[0] = a; state_vec[1] = b;
        state_vec[2] = c; state_vec[3] = d;
        if (push) push_frame(a, b, c, d);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            cyc++;
            if (done) begin
                exp_fid = exp_fid + 8'd1;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL done_timeout: got no done, required done");
    endtask

    initial begin
        int cyc;
        int d0;
        bit seen;
        reset = 1'b1; clk_en = 1'b0; start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) state_vec[i] = '0;
        repeat (3) tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_last",  32'(out_last),  0);
        check("rst_data",  32'(out_data),  0);
        check("rst_index", 32'(out_index), 0);
        check("rst_fid",   32'(frame_id),  0);
        check("rst_busy",  32'(busy),      0);
        check("rst_done",  32'(done),      0);
        check("rst_ovr",   32'(overrun),   0);
        reset = 1'b0;
        tick();

        // Basic frame, ready tied high.
        clk_en = 1'b1; out_ready = 1'b1;
        do_start(16'd9, 16'd7, 16'd6, 16'd4, 1'b1);
        check("lat_valid", 32'(out_valid), 1);
        check("lat_data",  32'(out_data),  9);
        check("lat_busy",  32'(busy),      1);
        d0 = done_cnt;
        wait_done(cyc);
        check("basic_cycles", 32'(cyc), 32'(NW));
        check("basic_fid", 32'(frame_id), 1);
        tick();
        check("basic_done_cnt", 32'(done_cnt - d0), 1);
        check("basic_idle_valid", 32'(out_valid), 0);
        check("basic_idle_busy", 32'(busy), 0);
        check("basic_done_clr", 32'(done), 0);

        // Backpressure on word index 1.
        do_start(16'd9, 16'd7, 16'd6, 16'd4, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (out_index == 3'd1) seen = 1'b1;
            else tick();
        end
        check("bp_reach_idx1", 32'(seen), 1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_data",  32'(out_data),  7);
            check("bp_index", 32'(out_index), 1);
            check("bp_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        wait_done(cyc);
        check("bp_fid", 32'(frame_id), 2);

        // clk_en toggling.
        do_start(16'h1234, 16'hABCD, 16'h0F0F, 16'h8001, 1'b1);
        seen = 1'b0;
        cyc = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            clk_en = ~clk_en;
            tick();
            cyc++;
            if (done) seen = 1'b1;
        end
        check("ce_done_seen", 32'(seen), 1);
        if (seen) exp_fid = exp_fid + 8'd1;
        check("ce_cycles", 32'(cyc), 32'(2 * NW));
        d0 = done_cnt;
        clk_en = 1'b0;
        tick();
        check("ce_done_hold", 32'(done), 1);
        clk_en = 1'b1;
        tick();
        check("ce_done_clr", 32'(done), 0);
        check("ce_done_cnt", 32'(done_cnt - d0), 1);
        check("ce_fid", 32'(frame_id), 3);

        // Overrun and snapshot isolation.
        check("ovr_pre", 32'(overrun), 0);
        do_start(16'd9, 16'd7, 16'd6, 16'd4, 1'b1);
        tick();
        do_start(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        check("ovr_set",  32'(overrun), 1);
        check("ovr_busy", 32'(busy),    1);
        wait_done(cyc);
        check("ovr_cycles", 32'(cyc), 32'(NW - 2));
        tick(); tick();
        check("ovr_no_restart", 32'(out_valid), 0);
        check("ovr_sticky", 32'(overrun), 1);

        // Reset mid-frame after two words.
        do_start(16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b1);
        tick(); tick();
        check("mr_index", 32'(out_index), 2);
        reset = 1'b1;
        sb.delete();
        exp_fid = 8'd0;
        #1;
        check("mr_valid", 32'(out_valid), 0);
        check("mr_data",  32'(out_data),  0);
        check("mr_index0", 32'(out_index), 0);
        check("mr_last",  32'(out_last),  0);
        check("mr_fid",   32'(frame_id),  0);
        check("mr_busy",  32'(busy),      0);
        check("mr_done",  32'(done),      0);
        check("mr_ovr",   32'(overrun),   0);
        tick();
        reset = 1'b0;
        tick();
        do_start(16'h00A0, 16'h00B0, 16'h00C0, 16'h00D0, 1'b1);
        wait_done(cyc);
        check("mr_new_fid", 32'(frame_id), 1);

        // Start in IDLE while done is still high.
        do_start(16'd5, 16'd6, 16'd7, 16'd8, 1'b1);
        check("dstart_valid", 32'(out_valid), 1);
        wait_done(cyc);
        check("dstart_ovr", 32'(overrun), 0);
        check("dstart_fid", 32'(frame_id), 2);

        // Run frames until frame_id wraps 255 -> 0.
        for (int f = 0; f < 254; f++) begin
            logic [15:0] v;
            v = 16'(f);
            do_start(v, v * 16'd3, ~v, v ^ 16'h5A5A, 1'b1);
            wait_done(cyc);
        end
        check("wrap_fid", 32'(frame_id), 0);
        check("wrap_model", 32'(exp_fid), 0);

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
